// File: rtl/gated_alu_fifo.sv
// gated_alu_fifo: latch-based clock gate driving a registered 16-function ALU,
// alongside an async FIFO carrying bytes from CLK into the R_CLK domain.
`timescale 1ns/1ps
`default_nettype none

module gated_alu_fifo #(
  parameter int OPERAND_WIDTH = 8,
  parameter int FUN_WIDTH     = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       R_CLK,
  input  logic                       R_RST,
  input  logic                       GATE_EN,
  input  logic [OPERAND_WIDTH-1:0]   A,
  input  logic [OPERAND_WIDTH-1:0]   B,
  input  logic [FUN_WIDTH-1:0]       ALU_FUN,
  input  logic                       ALU_EN,
  output logic [2*OPERAND_WIDTH-1:0] ALU_OUT,
  output logic                       OUT_VALID,
  input  logic                       W_INC,
  input  logic [DATA_WIDTH-1:0]      WR_DATA,
  input  logic                       R_INC,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [DATA_WIDTH-1:0]      RD_DATA
);

  localparam int RES_WIDTH = 2 * OPERAND_WIDTH;
  localparam int PW        = ADDR_WIDTH + 1;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  // Enable is only sampled while CLK is low, so alu_clk can never be chopped mid-pulse.
  logic gate_latch;
  logic alu_clk;

  always_latch begin
    if (!CLK) gate_latch <= GATE_EN;
  end

  assign alu_clk = CLK & gate_latch;

  logic [RES_WIDTH-1:0] a_ext, b_ext, result;
  assign a_ext = {{OPERAND_WIDTH{1'b0}}, A};
  assign b_ext = {{OPERAND_WIDTH{1'b0}}, B};

  always_comb begin
    result = '0;
    case (ALU_FUN)
      4'h0: result = a_ext + b_ext;
      4'h1: result = a_ext - b_ext;
      4'h2: result = a_ext * b_ext;
      4'h3: result = (B == '0) ? '0 : a_ext / b_ext;
      4'h4: result = {{OPERAND_WIDTH{1'b0}}, A & B};
      4'h5: result = {{OPERAND_WIDTH{1'b0}}, A | B};
      4'h6: result = {{OPERAND_WIDTH{1'b0}}, ~(A & B)};
      4'h7: result = {{OPERAND_WIDTH{1'b0}}, ~(A | B)};
      4'h8: result = {{OPERAND_WIDTH{1'b0}}, A ^ B};
      4'h9: result = {{OPERAND_WIDTH{1'b0}}, ~(A ^ B)};
      4'hA: result = (A == B) ? RES_WIDTH'(1) : '0;
      4'hB: result = (A > B)  ? RES_WIDTH'(2) : '0;
      4'hC: result = (A < B)  ? RES_WIDTH'(3) : '0;
      4'hD: result = a_ext >> 1;
      4'hE: result = a_ext << 1;
      default: result = '0;
    endcase
  end

  always_ff @(posedge alu_clk or negedge RST) begin
    if (!RST) begin
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
    end else if (ALU_EN) begin
      ALU_OUT   <= result;
      OUT_VALID <= 1'b1;
    end else begin
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wbin, wgray, wbin_next, wgray_next;
  logic [PW-1:0] rbin, rgray, rbin_next, rgray_next;
  logic [PW-1:0] rq [SYNC_STAGES];
  logic [PW-1:0] wq [SYNC_STAGES];
  logic [PW-1:0] rq_last, wq_last;
  logic          w_fire, r_fire;

  assign w_fire     = W_INC & ~FULL;
  assign r_fire     = R_INC & ~EMPTY;
  assign wbin_next  = wbin + PW'(w_fire);
  assign rbin_next  = rbin + PW'(r_fire);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign rq_last    = rq[SYNC_STAGES-1];
  assign wq_last    = wq[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (w_fire) mem[wbin[ADDR_WIDTH-1:0]] <= WR_DATA;
  end

  assign RD_DATA = mem[rbin[ADDR_WIDTH-1:0]];

  // Full when the writer is exactly one lap ahead: gray MSB pair inverted, rest equal.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wbin  <= '0;
      wgray <= '0;
      FULL  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) rq[i] <= '0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
      FULL  <= (wgray_next == {~rq_last[PW-1:PW-2], rq_last[PW-3:0]});
      rq[0] <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++) rq[i] <= rq[i-1];
    end
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      rbin  <= '0;
      rgray <= '0;
      EMPTY <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) wq[i] <= '0;
    end else begin
      rbin  <= rbin_next;
      rgray <= rgray_next;
      EMPTY <= (rgray_next == wq_last);
      wq[0] <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++) wq[i] <= wq[i-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gated_alu_fifo.sv
// Scoreboard bench for gated_alu_fifo: clock gating, ALU functions, async FIFO flags and ordering.
`timescale 1ns/1ps
`default_nettype none

module tb_gated_alu_fifo;

  logic        CLK = 1'b0, R_CLK = 1'b0;
  logic        RST = 1'b0, R_RST = 1'b0;
  logic        GATE_EN = 1'b0, ALU_EN = 1'b0, W_INC = 1'b0, R_INC = 1'b0;
  logic [7:0]  A = '0, B = '0, WR_DATA = '0;
  logic [3:0]  ALU_FUN = '0;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID, FULL, EMPTY;
  logic [7:0]  RD_DATA;

  int passed = 0;
  int total  = 0;
  int r_half = 7;

  logic [15:0] alu_q [$];
  logic [7:0]  fifo_q [$];

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  f;
    logic [15:0] e;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV] = '{
    {8'h14, 8'h0A, 4'h0, 16'h001E}, {8'h14, 8'h0A, 4'h1, 16'h000A},
    {8'h14, 8'h0A, 4'h2, 16'h00C8}, {8'h14, 8'h0A, 4'h3, 16'h0002},
    {8'h14, 8'h0A, 4'h4, 16'h0000}, {8'h14, 8'h0A, 4'h5, 16'h001E},
    {8'h14, 8'h0A, 4'h6, 16'h00FF}, {8'h14, 8'h0A, 4'h7, 16'h00E1},
    {8'h14, 8'h0A, 4'h8, 16'h001E}, {8'h14, 8'h0A, 4'h9, 16'h00E1},
    {8'h14, 8'h0A, 4'hA, 16'h0000}, {8'h14, 8'h0A, 4'hB, 16'h0002},
    {8'h14, 8'h0A, 4'hC, 16'h0000}, {8'h14, 8'h0A, 4'hD, 16'h000A},
    {8'h14, 8'h0A, 4'hE, 16'h0028}, {8'h14, 8'h0A, 4'hF, 16'h0000},
    {8'hFF, 8'hFF, 4'h2, 16'hFE01}, {8'hFF, 8'h01, 4'h0, 16'h0100},
    {8'h14, 8'h00, 4'h3, 16'h0000}, {8'h00, 8'h01, 4'h1, 16'hFFFF},
    {8'h07, 8'h07, 4'hA, 16'h0001}, {8'h03, 8'h09, 4'hC, 16'h0003},
    {8'hFF, 8'h01, 4'h1, 16'h00FE}
  };

  gated_alu_fifo dut (
    .CLK(CLK), .RST(RST), .R_CLK(R_CLK), .R_RST(R_RST),
    .GATE_EN(GATE_EN), .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .W_INC(W_INC), .WR_DATA(WR_DATA), .R_INC(R_INC),
    .FULL(FULL), .EMPTY(EMPTY), .RD_DATA(RD_DATA)
  );

  initial forever #5 CLK = ~CLK;
  // Half-ns offset keeps R_CLK edges from ever coinciding with CLK edges.
  initial begin
    #0.5;
    forever #(r_half) R_CLK = ~R_CLK;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic test_reset();
    #20;
    total++; if (ALU_OUT !== 16'h0) $display("FAIL reset_alu_out got %h exp 0000", ALU_OUT); else passed++;
    total++; if (OUT_VALID !== 1'b0) $display("FAIL reset_valid got %b exp 0", OUT_VALID); else passed++;
    total++; if (FULL !== 1'b0) $display("FAIL reset_full got %b exp 0", FULL); else passed++;
    total++; if (EMPTY !== 1'b1) $display("FAIL reset_empty got %b exp 1", EMPTY); else passed++;
    @(negedge CLK) RST = 1'b1;
    @(negedge R_CLK) R_RST = 1'b1;
  endtask

  task automatic test_gating();
    logic [15:0] e;
    @(negedge CLK);
    GATE_EN = 1'b0; ALU_EN = 1'b1; A = 8'd5; B = 8'd3; ALU_FUN = 4'h0;
    repeat (3) @(negedge CLK);
    total++; if (ALU_OUT !== 16'h0) $display("FAIL gated_off_out got %h exp 0000", ALU_OUT); else passed++;
    total++; if (OUT_VALID !== 1'b0) $display("FAIL gated_off_valid got %b exp 0", OUT_VALID); else passed++;
    GATE_EN = 1'b1;
    alu_q.push_back(16'd8);
    @(negedge CLK);
    e = alu_q.pop_front();
    total++; if (ALU_OUT !== e) $display("FAIL gate_on_out got %h exp %h", ALU_OUT, e); else passed++;
    total++; if (OUT_VALID !== 1'b1) $display("FAIL gate_on_valid got %b exp 1", OUT_VALID); else passed++;
    GATE_EN = 1'b0; ALU_FUN = 4'h2;
    repeat (2) @(negedge CLK);
    total++; if (ALU_OUT !== 16'd8) $display("FAIL gate_hold_out got %h exp 0008", ALU_OUT); else passed++;
    GATE_EN = 1'b1;
  endtask

  task automatic test_alu();
    logic [15:0] e;
    for (int i = 0; i < NV; i++) begin
      A = vecs[i].a; B = vecs[i].b; ALU_FUN = vecs[i].f; ALU_EN = 1'b1;
      alu_q.push_back(vecs[i].e);
      @(negedge CLK);
      e = alu_q.pop_front();
      total++; if (ALU_OUT !== e) $display("FAIL alu_vec%0d fun %h got %h exp %h", i, vecs[i].f, ALU_OUT, e); else passed++;
      total++; if (OUT_VALID !== 1'b1) $display("FAIL alu_valid%0d got %b exp 1", i, OUT_VALID); else passed++;
    end
    ALU_EN = 1'b0;
    @(negedge CLK);
    total++; if (ALU_OUT !== 16'h0) $display("FAIL alu_en_off_out got %h exp 0000", ALU_OUT); else passed++;
    total++; if (OUT_VALID !== 1'b0) $display("FAIL alu_en_off_valid got %b exp 0", OUT_VALID); else passed++;
  endtask

  task automatic test_fifo_fill();
    @(negedge CLK);
    W_INC = 1'b1; WR_DATA = 8'h01; fifo_q.push_back(8'h01);
    @(posedge CLK); #1 W_INC = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge R_CLK); #1;
      if (!EMPTY) break;
    end
    total++; if (EMPTY !== 1'b0) $display("FAIL fill_empty_clear got %b exp 0", EMPTY); else passed++;
    total++; if (RD_DATA !== fifo_q[0]) $display("FAIL fill_first_word got %h exp %h", RD_DATA, fifo_q[0]); else passed++;
    for (int v = 2; v <= 8; v++) begin
      @(negedge CLK);
      if (v == 8) begin
        total++; if (FULL !== 1'b0) $display("FAIL fill_not_full7 got %b exp 0", FULL); else passed++;
      end
      W_INC = 1'b1; WR_DATA = 8'(v); fifo_q.push_back(8'(v));
    end
    @(negedge CLK);
    total++; if (FULL !== 1'b1) $display("FAIL fill_full8 got %b exp 1", FULL); else passed++;
    WR_DATA = 8'h09;
    @(negedge CLK);
    W_INC = 1'b0;
    total++; if (FULL !== 1'b1) $display("FAIL fill_full9 got %b exp 1", FULL); else passed++;
  endtask

  task automatic test_fifo_drain();
    logic [7:0] e;
    @(negedge R_CLK);
    e = fifo_q.pop_front();
    total++; if (RD_DATA !== e) $display("FAIL drain_word0 got %h exp %h", RD_DATA, e); else passed++;
    R_INC = 1'b1;
    @(posedge R_CLK); #1 R_INC = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      if (!FULL) break;
    end
    total++; if (FULL !== 1'b0) $display("FAIL drain_full_clear got %b exp 0", FULL); else passed++;
    for (int i = 1; i < 8; i++) begin
      @(negedge R_CLK);
      e = fifo_q.pop_front();
      total++; if (RD_DATA !== e || EMPTY !== 1'b0) $display("FAIL drain_word%0d got %h empty %b exp %h empty 0", i, RD_DATA, EMPTY, e); else passed++;
      R_INC = 1'b1;
    end
    @(negedge R_CLK);
    total++; if (EMPTY !== 1'b1) $display("FAIL drain_empty got %b exp 1", EMPTY); else passed++;
    @(negedge R_CLK);
    R_INC = 1'b0;
    total++; if (EMPTY !== 1'b1) $display("FAIL drain_extra_rd got %b exp 1", EMPTY); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    r_half = 150;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      W_INC = 1'b1; WR_DATA = 8'hA0 + 8'(i); fifo_q.push_back(8'hA0 + 8'(i));
      @(negedge CLK);
      W_INC = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge R_CLK);
        if (!EMPTY) break;
      end
      e = fifo_q.pop_front();
      total++; if (EMPTY !== 1'b0 || RD_DATA !== e) $display("FAIL wrap_word%0d got %h empty %b exp %h empty 0", i, RD_DATA, EMPTY, e); else passed++;
      R_INC = 1'b1;
      @(negedge R_CLK);
      R_INC = 1'b0;
      total++; if (EMPTY !== 1'b1) $display("FAIL wrap_empty%0d got %b exp 1", i, EMPTY); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    @(negedge CLK);
    GATE_EN = 1'b1; ALU_EN = 1'b1; A = 8'd5; B = 8'd3; ALU_FUN = 4'h0;
    for (int i = 0; i < 3; i++) begin
      W_INC = 1'b1; WR_DATA = 8'h30 + 8'(i);
      @(negedge CLK);
    end
    W_INC = 1'b0;
    total++; if (ALU_OUT !== 16'd8) $display("FAIL mid_alu_pre got %h exp 0008", ALU_OUT); else passed++;
    for (int k = 0; k < 5; k++) begin
      @(negedge R_CLK);
      if (!EMPTY) break;
    end
    total++; if (EMPTY !== 1'b0) $display("FAIL mid_empty_pre got %b exp 0", EMPTY); else passed++;
    #3;
    RST = 1'b0; R_RST = 1'b0;
    #3;
    total++; if (EMPTY !== 1'b1) $display("FAIL mid_rst_empty got %b exp 1", EMPTY); else passed++;
    total++; if (FULL !== 1'b0) $display("FAIL mid_rst_full got %b exp 0", FULL); else passed++;
    total++; if (ALU_OUT !== 16'h0) $display("FAIL mid_rst_alu got %h exp 0000", ALU_OUT); else passed++;
    total++; if (OUT_VALID !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", OUT_VALID); else passed++;
    fifo_q.delete();
    ALU_EN = 1'b0;
    r_half = 7;
    #400;
    @(negedge CLK) RST = 1'b1;
    @(negedge R_CLK) R_RST = 1'b1;
    @(negedge CLK);
    W_INC = 1'b1; WR_DATA = 8'h5A; fifo_q.push_back(8'h5A);
    @(negedge CLK);
    W_INC = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge R_CLK);
      if (!EMPTY) break;
    end
    e = fifo_q.pop_front();
    total++; if (EMPTY !== 1'b0 || RD_DATA !== e) $display("FAIL post_rst_word got %h empty %b exp %h empty 0", RD_DATA, EMPTY, e); else passed++;
    total++; if (FULL !== 1'b0) $display("FAIL post_rst_full got %b exp 0", FULL); else passed++;
  endtask

  initial begin
    test_reset();
    test_gating();
    test_alu();
    test_fifo_fill();
    test_fifo_drain();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
